// File: rtl/rs_decode_chien_forney.sv
// Chien search and Forney error-magnitude stage for the GF(2^6) Reed-Solomon decoder.
// Scans all N codeword positions, highest degree first, one per clock. For each position
// it reports whether Lambda has a root there and, if so, the error magnitude.
module rs_decode_chien_forney #(
    parameter int unsigned N = 63,
    parameter int unsigned T = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [6*(T+1)-1:0] lambda,
    input  logic [6*T-1:0]     omega,
    input  logic [2:0]         num_err,
    output logic               busy,
    output logic               out_valid,
    output logic [5:0]         out_pos,
    output logic               err_flag,
    output logic [5:0]         err_val,
    output logic               done,
    output logic [2:0]         err_cnt,
    output logic               fail
);

    // ------------------------------------------------------------------
    // GF(2^6) arithmetic, primitive polynomial x^6+x^5+x^4+x+1, alpha = 2
    // ------------------------------------------------------------------

    // Multiply a by x and reduce; x^6 folds back to x^5+x^4+x+1 (0x33).
    function automatic logic [5:0] gf_xtime(input logic [5:0] a);
        return a[5] ? ({a[4:0], 1'b0} ^ 6'h33) : {a[4:0], 1'b0};
    endfunction

    // General shift-and-add multiplier; constant operands fold to XOR networks.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] acc;
        logic [5:0] sh;
        acc = 6'd0;
        sh  = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // alpha^e, used only with elaboration-time constant exponents.
    function automatic logic [5:0] gf_pow(input int unsigned e);
        logic [5:0] p;
        p = 6'd1;
        for (int unsigned i = 0; i < (e % 63); i++) begin
            p = gf_xtime(p);
        end
        return p;
    endfunction

    // Inverse as a^62 = a^2 * a^4 * a^8 * a^16 * a^32; inv(0) falls out as 0.
    function automatic logic [5:0] gf_inv(input logic [5:0] a);
        logic [5:0] sq;
        logic [5:0] res;
        sq  = a;
        res = 6'd1;
        for (int i = 0; i < 5; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_t;

    state_t     r_state;
    logic [5:0] r_cnt;
    logic [2:0] r_num_err;
    logic       r_busy;

    // Chien registers: r_loc[k] tracks lambda_k * x^k, r_eval[k] tracks omega_k * x^(k+1).
    logic [5:0] r_loc  [T+1];
    logic [5:0] r_eval [T];

    // Pipeline stage 1
    logic       r_s1_valid;
    logic [5:0] r_s1_l;
    logic [5:0] r_s1_odd;
    logic [5:0] r_s1_w;
    logic [5:0] r_s1_pos;

    // Pipeline stage 2 / outputs
    logic       r_out_valid;
    logic [5:0] r_out_pos;
    logic       r_err_flag;
    logic [5:0] r_err_val;
    logic       r_done;
    logic [2:0] r_err_cnt;
    logic       r_fail;
    logic       r_bad_root;

    // Combinational nets
    logic [5:0] w_loc_init  [T+1];
    logic [5:0] w_loc_step  [T+1];
    logic [5:0] w_eval_init [T];
    logic [5:0] w_eval_step [T];
    logic [5:0] w_sum_l;
    logic [5:0] w_sum_odd;
    logic [5:0] w_sum_w;
    logic [5:0] w_pos;
    logic [5:0] w_mag;
    logic       w_s1_root;
    logic       w_s1_last;
    logic [2:0] w_cnt_next;
    logic       w_bad_next;

    // ------------------------------------------------------------------
    // Constant multipliers: load scaling starts the scan at x = alpha^-(N-1),
    // step scaling advances x by alpha each cycle.
    // ------------------------------------------------------------------
    for (genvar k = 0; k <= T; k++) begin : g_loc
        localparam logic [5:0] LocInitC = gf_pow((63 - (k * (N - 1)) % 63) % 63);
        localparam logic [5:0] LocStepC = gf_pow(k);
        assign w_loc_init[k] = gf_mul(lambda[6*k +: 6], LocInitC);
        assign w_loc_step[k] = gf_mul(r_loc[k], LocStepC);
    end

    for (genvar k = 0; k < T; k++) begin : g_eval
        localparam logic [5:0] EvalInitC = gf_pow((63 - ((k + 1) * (N - 1)) % 63) % 63);
        localparam logic [5:0] EvalStepC = gf_pow(k + 1);
        assign w_eval_init[k] = gf_mul(omega[6*k +: 6], EvalInitC);
        assign w_eval_step[k] = gf_mul(r_eval[k], EvalStepC);
    end

    // Evaluate Lambda(x), x*Lambda'(x) (odd terms) and x*Omega(x) at the current point.
    always_comb begin
        w_sum_l   = 6'd0;
        w_sum_odd = 6'd0;
        w_sum_w   = 6'd0;
        for (int k = 0; k <= int'(T); k++) begin
            w_sum_l = w_sum_l ^ r_loc[k];
            if ((k % 2) == 1) begin
                w_sum_odd = w_sum_odd ^ r_loc[k];
            end
        end
        for (int k = 0; k < int'(T); k++) begin
            w_sum_w = w_sum_w ^ r_eval[k];
        end
    end

    // Position for the current evaluation, magnitude and bookkeeping for stage 2.
    always_comb begin
        w_pos      = 6'(N - 1) - r_cnt;
        // x*Omega / (x*Lambda') equals Omega / Lambda' at the root.
        w_mag      = gf_mul(r_s1_w, gf_inv(r_s1_odd));
        w_s1_root  = r_s1_valid && (r_s1_l == 6'd0);
        w_s1_last  = r_s1_valid && (r_s1_pos == 6'd0);
        w_cnt_next = r_err_cnt + {2'b00, w_s1_root};
        w_bad_next = r_bad_root | (w_s1_root & (r_s1_odd == 6'd0));
    end

    // Control FSM, Chien register updates and both pipeline stages.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_cnt       <= 6'd0;
            r_num_err   <= 3'd0;
            r_busy      <= 1'b0;
            for (int k = 0; k <= int'(T); k++) begin
                r_loc[k] <= 6'd0;
            end
            for (int k = 0; k < int'(T); k++) begin
                r_eval[k] <= 6'd0;
            end
            r_s1_valid  <= 1'b0;
            r_s1_l      <= 6'd0;
            r_s1_odd    <= 6'd0;
            r_s1_w      <= 6'd0;
            r_s1_pos    <= 6'd0;
            r_out_valid <= 1'b0;
            r_out_pos   <= 6'd0;
            r_err_flag  <= 1'b0;
            r_err_val   <= 6'd0;
            r_done      <= 1'b0;
            r_err_cnt   <= 3'd0;
            r_fail      <= 1'b0;
            r_bad_root  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k <= int'(T); k++) begin
                            r_loc[k] <= w_loc_init[k];
                        end
                        for (int k = 0; k < int'(T); k++) begin
                            r_eval[k] <= w_eval_init[k];
                        end
                        r_num_err  <= num_err;
                        r_cnt      <= 6'd0;
                        r_err_cnt  <= 3'd0;
                        r_fail     <= 1'b0;
                        r_bad_root <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    for (int k = 0; k <= int'(T); k++) begin
                        r_loc[k] <= w_loc_step[k];
                    end
                    for (int k = 0; k < int'(T); k++) begin
                        r_eval[k] <= w_eval_step[k];
                    end
                    if (r_cnt == 6'(N - 1)) begin
                        r_cnt   <= 6'd0;
                        r_state <= StFlush;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                StFlush: begin
                    // Two drain cycles; the second one carries done.
                    if (r_cnt == 6'd1) begin
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase

            // Stage 1: capture the sums for the position evaluated this cycle.
            r_s1_valid <= (r_state == StRun);
            r_s1_l     <= w_sum_l;
            r_s1_odd   <= w_sum_odd;
            r_s1_w     <= w_sum_w;
            r_s1_pos   <= w_pos;

            // Stage 2: registered per-position outputs.
            r_out_valid <= r_s1_valid;
            r_out_pos   <= r_s1_valid ? r_s1_pos : 6'd0;
            r_err_flag  <= w_s1_root;
            r_err_val   <= w_s1_root ? w_mag : 6'd0;
            r_done      <= w_s1_last;

            // Count roots at stage 2 entry so the final count is ready alongside done.
            if (r_s1_valid) begin
                r_err_cnt  <= w_cnt_next;
                r_bad_root <= w_bad_next;
            end
            if (w_s1_last) begin
                r_fail <= (w_cnt_next != r_num_err) || w_bad_next;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_pos   = r_out_pos;
    assign err_flag  = r_err_flag;
    assign err_val   = r_err_val;
    assign done      = r_done;
    assign err_cnt   = r_err_cnt;
    assign fail      = r_fail;

endmodule

// File: tb/tb_rs_decode_chien_forney.sv
// Scoreboard bench for rs_decode_chien_forney: the driver queues the expected per-position
// stream and final status for each job; a negedge monitor pops and compares.
module tb_rs_decode_chien_forney;

    localparam int N = 63;
    localparam int T = 4;

    localparam logic [29:0] L_NONE = {6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
    localparam logic [23:0] O_NONE = {6'd0, 6'd0, 6'd0, 6'd0};
    localparam logic [29:0] L_POS5 = {6'd0, 6'd0, 6'd0, 6'd32, 6'd1};
    localparam logic [23:0] O_POS5 = {6'd0, 6'd0, 6'd0, 6'd51};
    localparam logic [29:0] L_POS0 = {6'd0, 6'd0, 6'd0, 6'd1, 6'd1};
    localparam logic [23:0] O_POS0 = {6'd0, 6'd0, 6'd0, 6'd1};

    logic                CLK;
    logic                RESET;
    logic                start;
    logic [6*(T+1)-1:0]  lambda;
    logic [6*T-1:0]      omega;
    logic [2:0]          num_err;
    logic                busy;
    logic                out_valid;
    logic [5:0]          out_pos;
    logic                err_flag;
    logic [5:0]          err_val;
    logic                done;
    logic [2:0]          err_cnt;
    logic                fail;

    typedef struct {
        int pos;
        int flag;
        int val;
        int cyc;
    } exp_t;

    typedef struct {
        int cnt;
        int fl;
    } sum_t;

    exp_t exp_q[$];
    sum_t sum_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    rs_decode_chien_forney #(
        .N(N),
        .T(T)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .lambda   (lambda),
        .omega    (omega),
        .num_err  (num_err),
        .busy     (busy),
        .out_valid(out_valid),
        .out_pos  (out_pos),
        .err_flag (err_flag),
        .err_val  (err_val),
        .done     (done),
        .err_cnt  (err_cnt),
        .fail     (fail)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue the expected stream (first nexp positions) and optionally the final status,
    // then pulse start. Called at a negedge; returns one negedge later.
    task automatic start_job(input logic [29:0] l, input logic [23:0] o, input logic [2:0] ne,
                             input int epos, input int ev, input int ecnt, input int efail,
                             input int nexp, input bit psum);
        exp_t e;
        sum_t s;
        for (int i = 0; i < nexp; i++) begin
            e.pos  = N - 1 - i;
            e.flag = (e.pos == epos) ? 1 : 0;
            e.val  = (e.pos == epos) ? ev : 0;
            e.cyc  = cyc + 3 + i;
            exp_q.push_back(e);
        end
        if (psum) begin
            s.cnt = ecnt;
            s.fl  = efail;
            sum_q.push_back(s);
        end
        lambda  = l;
        omega   = o;
        num_err = ne;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    // Wait (bounded) for done; returns at the negedge of the cycle after done.
    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 300 cycles (cycle %0d)", cyc);
        end else begin
            chk("busy_on_done", int'(busy), 1);
            @(negedge CLK);
            chk("busy_after_done", int'(busy), 0);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        sum_t s;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got pos %0d expected no output", out_pos);
            end else begin
                e = exp_q.pop_front();
                chk("out_pos", int'(out_pos), e.pos);
                chk("err_flag", int'(err_flag), e.flag);
                chk("err_val", int'(err_val), e.val);
                chk("out_cycle", cyc, e.cyc);
                chk("done_on_last", int'(done), (e.pos == 0) ? 1 : 0);
                if (done) begin
                    if (sum_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done expected none at cycle %0d", cyc);
                    end else begin
                        s = sum_q.pop_front();
                        chk("err_cnt", int'(err_cnt), s.cnt);
                        chk("fail", int'(fail), s.fl);
                    end
                end
            end
        end else if (done) begin
            checks++;
            failures++;
            $display("FAIL done_without_valid: got done=1 expected out_valid=1");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET   = 1'b1;
        start   = 1'b0;
        lambda  = '0;
        omega   = '0;
        num_err = 3'd0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_err_flag", int'(err_flag), 0);
        chk("rst_err_val", int'(err_val), 0);
        chk("rst_out_pos", int'(out_pos), 0);
        RESET = 1'b0;
        @(negedge CLK);

        // No error
        start_job(L_NONE, O_NONE, 3'd0, -1, 0, 0, 0, N, 1'b1);
        wait_done();
        repeat (2) @(negedge CLK);

        // Single error at position 5, magnitude 2
        start_job(L_POS5, O_POS5, 3'd1, 5, 2, 1, 0, N, 1'b1);
        wait_done();
        repeat (2) @(negedge CLK);

        // Error at position 0, magnitude 1 (last output, with done)
        start_job(L_POS0, O_POS0, 3'd1, 0, 1, 1, 0, N, 1'b1);
        wait_done();
        repeat (2) @(negedge CLK);

        // Count mismatch: solver claims two errors
        start_job(L_POS5, O_POS5, 3'd2, 5, 2, 1, 1, N, 1'b1);
        wait_done();
        repeat (2) @(negedge CLK);

        // Start re-pulsed mid-run is ignored; then back-to-back job the cycle after done
        start_job(L_POS5, O_POS5, 3'd1, 5, 2, 1, 0, N, 1'b1);
        repeat (10) @(negedge CLK);
        lambda  = L_POS0;
        omega   = O_POS0;
        num_err = 3'd3;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done();
        start_job(L_POS0, O_POS0, 3'd1, 0, 1, 1, 0, N, 1'b1);
        wait_done();
        repeat (2) @(negedge CLK);

        // Reset at run cycle 20: evaluations 0..18 have reached the outputs, nothing after
        start_job(L_POS5, O_POS5, 3'd1, 5, 2, 1, 0, 19, 1'b0);
        repeat (20) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_done", int'(done), 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        chk("midrst_stream_cut", exp_q.size(), 0);

        // After reset, behaves as the no-error case
        start_job(L_NONE, O_NONE, 3'd0, -1, 0, 0, 0, N, 1'b1);
        wait_done();
        repeat (5) @(negedge CLK);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("sum_q_drained", sum_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
